bullet_pool: RTL
================

// Module: bullet_pool
// PURPOSE
//  Parametrised pool of NUM_BULLETS player projectiles: spawns on fire, advances one step per frame,
//  retires on screen exit or hit, and reports per-bullet pixel coverage to the colour mapper.
//  Sits between the keycode/player logic and the colour mapper; the hit vector comes from collision detect.
// PARAMETERS
//  NUM_BULLETS     6    pool depth (slots), 1..16
//  SPEED           4    pixels moved per frame tick
//  BULLET_SIZE     4    square bullet edge, pixels
//  SCREEN_W        640  visible width;  valid X range 0..SCREEN_W-1
//  SCREEN_H        480  visible height; valid Y range 0..SCREEN_H-1
//  COOLDOWN        8    frame ticks between accepted shots (0 = no cooldown)
// PORTS
//  Clk          in   1            system clock
//  Reset_n      in   1            asynchronous reset, active-low
//  VS           in   1            vertical sync (async to frame logic); rising edge = frame tick
//  fire         in   1            shoot request, level or pulse
//  direction    in   1            player facing: 1 = right, 0 = left
//  PlayerX      in   10           player left edge
//  PlayerY      in   10           player top edge
//  PlayerWidth  in   10           player width
//  PlayerHeight in   10           player height
//  hit          in   NUM_BULLETS  per-slot collision pulse
//  DrawX        in   10           current pixel X
//  DrawY        in   10           current pixel Y
//  bullet_on    out  NUM_BULLETS  slot i covers (DrawX,DrawY)
//  active_count out  5            number of live slots
//  fire_ack     out  1            1-cycle pulse: shot accepted
//  fire_drop    out  1            1-cycle pulse: shot rejected (pool full / off-screen spawn)
// BEHAVIOUR
//  Reset: all slots inactive, cooldown=0, fire latch clear, VS sync regs 0; bullet_on=0,
//   active_count=0, fire_ack=0, fire_drop=0.
//  VS is double-flopped into Clk; tick = 1-cycle pulse on the synced rising edge.
//  Slot state (registered): active, X[9:0], Y[9:0], dir.
//  fire sets a sticky latch on any cycle; latch is consumed/cleared on the next tick.
//  On tick, in order, per slot:
//   1) hit[i] asserted this cycle -> retire (hit at any cycle retires next edge; hit wins over move).
//   2) active & dir=1: X+SPEED > SCREEN_W-1 -> retire, else X += SPEED.
//      active & dir=0: X < SPEED -> retire, else X -= SPEED. Compare in 11 bits, no wrap.
//  Spawn on tick, when latch=1 and cooldown=0:
//   - slot = lowest-index slot inactive after step 1/2 (a slot freed this tick is reusable).
//   - right: X = PlayerX+PlayerWidth; left: X = PlayerX-BULLET_SIZE; Y = PlayerY+(PlayerHeight>>1).
//   - spawned bullet is not moved on its spawn tick; dir captured from direction.
//   - reject (fire_drop) if no free slot, or left spawn with PlayerX < BULLET_SIZE,
//     or right spawn X > SCREEN_W-1; otherwise fire_ack and cooldown = COOLDOWN.
//  latch=1 with cooldown>0 on tick: request silently discarded (no ack/drop).
//  Cooldown decrements by 1 per tick, saturates at 0 (decrement happens on ticks without a spawn).
//  fire_ack/fire_drop registered, asserted the cycle after the tick edge.
//  bullet_on[i] combinational: active & X<=DrawX<X+BULLET_SIZE & Y<=DrawY<Y+BULLET_SIZE.
//  active_count: registered popcount of active, updated with slot state.
//  Reset_n low mid-frame: all slots cleared immediately; no spawn until a fresh fire after release.
// TESTING
//  Reset, fire=1, dir=1, PlayerX=100, W=20, Y=200, H=40, one VS edge -> slot0 X=120 Y=220, fire_ack, count=1.
//  Slot0 at X=636, SPEED=4, tick -> retired, bullet_on[0]=0, count=0; left: X=3 -> retired.
//  Fire held 7 frames, COOLDOWN=8 -> only 1 ack; ack again on tick 9 after the first ack.
//  COOLDOWN=0, fire each frame with 6 live slots -> fire_drop, count stays 6; hit[2] + fire same tick -> slot2 reused.
//  hit[0] asserted mid-frame -> slot0 inactive next cycle; bullet_on[0]=0 at DrawX=120, DrawY=220.
//  Pixel check: bullet at (120,220) -> bullet_on[0]=1 for (120..123, 220..223), 0 at (124,220); reset mid-flight -> all 0.

Source files
------------

// File: rtl/bullet_pool.sv
// Pool of player projectiles: frame-ticked movement, spawn on fire with cooldown,
// retirement on screen exit or hit, and per-slot pixel coverage for the colour mapper.
module bullet_pool #(
   parameter int NUM_BULLETS = 6,
   parameter int SPEED       = 4,
   parameter int BULLET_SIZE = 4,
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int COOLDOWN    = 8
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   input  logic                   VS,
   input  logic                   fire,
   input  logic                   direction,
   input  logic [9:0]             PlayerX,
   input  logic [9:0]             PlayerY,
   input  logic [9:0]             PlayerWidth,
   input  logic [9:0]             PlayerHeight,
   input  logic [NUM_BULLETS-1:0] hit,
   input  logic [9:0]             DrawX,
   input  logic [9:0]             DrawY,
   output logic [NUM_BULLETS-1:0] bullet_on,
   output logic [4:0]             active_count,
   output logic                   fire_ack,
   output logic                   fire_drop
);

   localparam int          CD_W    = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
   localparam logic [10:0] SPD11   = 11'(SPEED);
   localparam logic [9:0]  SPD10   = 10'(SPEED);
   localparam logic [10:0] BS11    = 11'(BULLET_SIZE);
   localparam logic [9:0]  BS10    = 10'(BULLET_SIZE);
   localparam logic [10:0] XMAX11  = 11'(SCREEN_W - 1);
   localparam logic [10:0] YMAX11  = 11'(SCREEN_H - 1);
   localparam logic [CD_W-1:0] CD_INIT = CD_W'(COOLDOWN);

   logic [1:0]             vs_sync_reg;
   logic                   vs_prev_reg;
   logic                   tick;
   logic                   latch_reg;
   logic [CD_W-1:0]        cooldown_reg;
   logic [NUM_BULLETS-1:0] active_reg;
   logic [NUM_BULLETS-1:0] active_next;
   logic [NUM_BULLETS-1:0] keep;
   logic [NUM_BULLETS-1:0] free;
   logic [NUM_BULLETS-1:0] sel;
   logic [9:0]             x_reg   [NUM_BULLETS];
   logic [9:0]             y_reg   [NUM_BULLETS];
   logic                   dir_reg [NUM_BULLETS];
   logic [9:0]             moved_x [NUM_BULLETS];
   logic [4:0]             count_next;
   logic [10:0]            sum_x11;
   logic [10:0]            spawn_y11;
   logic [9:0]             spawn_x;
   logic                   off_screen;
   logic                   attempt;
   logic                   accept;
   logic                   drop;
   logic [10:0]            dxe;
   logic [10:0]            dye;

   assign tick = vs_sync_reg[1] & ~vs_prev_reg;
   assign dxe  = {1'b0, DrawX};
   assign dye  = {1'b0, DrawY};

   // Per-slot step: a hit retires on any cycle; movement/exit only on a tick.
   generate
      for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
         logic [10:0] xe;
         logic [10:0] ye;
         logic        exits;
         assign xe    = {1'b0, x_reg[gi]};
         assign ye    = {1'b0, y_reg[gi]};
         assign exits = dir_reg[gi] ? ((xe + SPD11) > XMAX11) : (xe < SPD11);
         assign keep[gi] = active_reg[gi] & ~hit[gi] & ~(tick & exits);
         assign moved_x[gi] = dir_reg[gi] ? (x_reg[gi] + SPD10) : (x_reg[gi] - SPD10);
         assign bullet_on[gi] = active_reg[gi] &&
                                (dxe >= xe) && (dxe < xe + BS11) &&
                                (dye >= ye) && (dye < ye + BS11);
      end
   endgenerate

   // Lowest-index free slot, evaluated after retirements so a slot freed this tick is reusable.
   assign free = ~keep;
   assign sel  = free & (~free + NUM_BULLETS'(1));

   assign sum_x11   = {1'b0, PlayerX} + {1'b0, PlayerWidth};
   assign spawn_y11 = {1'b0, PlayerY} + {1'b0, (PlayerHeight >> 1)};
   assign spawn_x   = direction ? sum_x11[9:0] : (PlayerX - BS10);
   assign off_screen = (direction ? (sum_x11 > XMAX11) : (PlayerX < BS10)) ||
                       (spawn_y11 > YMAX11);

   assign attempt = tick & (latch_reg | fire) & (cooldown_reg == '0);
   assign accept  = attempt & (|free) & ~off_screen;
   assign drop    = attempt & ~accept;
   assign active_next = keep | (accept ? sel : '0);

   always_comb begin
      count_next = '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         count_next = count_next + 5'(active_next[i]);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         vs_sync_reg  <= '0;
         vs_prev_reg  <= 1'b0;
         latch_reg    <= 1'b0;
         cooldown_reg <= '0;
         active_reg   <= '0;
         active_count <= '0;
         fire_ack     <= 1'b0;
         fire_drop    <= 1'b0;
         for (int i = 0; i < NUM_BULLETS; i++) begin
            x_reg[i]   <= '0;
            y_reg[i]   <= '0;
            dir_reg[i] <= 1'b0;
         end
      end else begin
         vs_sync_reg  <= {vs_sync_reg[0], VS};
         vs_prev_reg  <= vs_sync_reg[1];
         latch_reg    <= tick ? 1'b0 : (latch_reg | fire);
         fire_ack     <= accept;
         fire_drop    <= drop;
         active_reg   <= active_next;
         active_count <= count_next;
         if (accept) begin
            cooldown_reg <= CD_INIT;
         end else if (tick && cooldown_reg != '0) begin
            cooldown_reg <= cooldown_reg - 1'b1;
         end
         for (int i = 0; i < NUM_BULLETS; i++) begin
            if (accept && sel[i]) begin
               x_reg[i]   <= spawn_x;
               y_reg[i]   <= spawn_y11[9:0];
               dir_reg[i] <= direction;
            end else if (tick && active_reg[i]) begin
               x_reg[i]   <= moved_x[i];
            end
         end
      end
   end

endmodule
